// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one variable-latency memory between fetch and the MEM stage,
// giving data priority under a fetch starvation bound and aborting hung accesses.
module mem_port_arbiter #(
    parameter int WIDTH        = 32,
    parameter int STARVE_LIMIT = 4,
    parameter int TIMEOUT_CYC  = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             if_req,
    input  logic [WIDTH-1:0] if_addr,
    input  logic             flush_F,
    output logic [WIDTH-1:0] if_rdata,
    output logic             if_valid,
    output logic             stall_F,
    input  logic             dm_req,
    input  logic             dm_we,
    input  logic [WIDTH-1:0] dm_addr,
    input  logic [WIDTH-1:0] dm_wdata,
    output logic [WIDTH-1:0] dm_rdata,
    output logic             dm_valid,
    output logic             stall_MEM,
    output logic             mem_req,
    output logic             mem_we,
    output logic [WIDTH-1:0] mem_addr,
    output logic [WIDTH-1:0] mem_wdata,
    input  logic [WIDTH-1:0] mem_rdata,
    input  logic             mem_ack,
    output logic             timeout_err
);
    typedef enum logic [1:0] {IDLE, IF_BUSY, DM_BUSY, RESP} state_t;
    state_t     state, state_nxt;
    logic [3:0] starve_cnt;
    logic [7:0] wd_cnt;
    logic       drop, owner_dm, if_eff, busy, grant_dm, grant_if, wd_exp;

    always_comb begin
        if_eff    = if_req & ~flush_F;
        busy      = (state == IF_BUSY) | (state == DM_BUSY);
        grant_dm  = (state == IDLE) & dm_req & ~(if_eff & (starve_cnt == 4'(STARVE_LIMIT)));
        grant_if  = (state == IDLE) & ~grant_dm & if_eff;
        wd_exp    = busy & ~mem_ack & (wd_cnt == 8'(TIMEOUT_CYC - 1));
        state_nxt = state;
        case (state)
            IDLE:             if (grant_dm) state_nxt = DM_BUSY;
                              else if (grant_if) state_nxt = IF_BUSY;
            IF_BUSY, DM_BUSY: if (mem_ack) state_nxt = RESP;
                              else if (wd_exp) state_nxt = IDLE;
            default:          state_nxt = IDLE;
        endcase
    end

    assign mem_req   = busy;
    assign if_valid  = (state == RESP) & ~owner_dm & ~drop;
    assign dm_valid  = (state == RESP) & owner_dm;
    assign stall_F   = if_req & ~if_valid & ~flush_F;
    assign stall_MEM = dm_req & ~dm_valid;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            starve_cnt  <= '0;
            wd_cnt      <= '0;
            drop        <= 1'b0;
            owner_dm    <= 1'b0;
            mem_we      <= 1'b0;
            mem_addr    <= '0;
            mem_wdata   <= '0;
            if_rdata    <= '0;
            dm_rdata    <= '0;
            timeout_err <= 1'b0;
        end else begin
            state       <= state_nxt;
            timeout_err <= wd_exp;
            if (grant_dm | grant_if) begin
                mem_addr   <= grant_dm ? dm_addr : if_addr;
                mem_we     <= grant_dm & dm_we;
                mem_wdata  <= grant_dm ? dm_wdata : '0;
                owner_dm   <= grant_dm;
                drop       <= 1'b0;
                wd_cnt     <= '0;
                starve_cnt <= (grant_dm & if_eff) ? starve_cnt + 4'd1 : 4'd0;
            end else if (busy) begin
                wd_cnt <= wd_cnt + 8'd1;
            end
            // a flush landing on the ack cycle still suppresses the capture
            if (state == IF_BUSY && flush_F)
                drop <= 1'b1;
            if (state == IF_BUSY && mem_ack && !drop && !flush_F)
                if_rdata <= mem_rdata;
            if (state == DM_BUSY && mem_ack && !mem_we)
                dm_rdata <= mem_rdata;
        end
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: randomized fetch/data traffic against a reference memory model,
// with queued expected responses checked by an independent monitor.
module tb_mem_port_arbiter;
    localparam int W  = 32;
    localparam int SL = 4;
    localparam int TO = 8;

    logic          clk = 0, rst = 0;
    logic          if_req = 0, flush_F = 0, dm_req = 0, dm_we = 0, mem_ack = 0;
    logic [W-1:0]  if_addr = 0, dm_addr = 0, dm_wdata = 0, mem_rdata = 0;
    logic [W-1:0]  if_rdata, dm_rdata, mem_addr, mem_wdata;
    logic          if_valid, stall_F, dm_valid, stall_MEM, mem_req, mem_we, timeout_err;

    int vectors = 0, miscompares = 0;
    logic [W-1:0] if_q[$], dm_q[$];
    logic [W-1:0] if_last = 0, dm_last = 0, dm_last_model = 0;
    logic [W-1:0] dmem[logic [W-1:0]], ref_mem[logic [W-1:0]];
    int  dm_since_if = 0;
    bit  chk_starve = 0, no_to = 0, mute = 0;

    mem_port_arbiter #(.WIDTH(W), .STARVE_LIMIT(SL), .TIMEOUT_CYC(TO)) dut (
        .clk(clk), .rst(rst), .if_req(if_req), .if_addr(if_addr), .flush_F(flush_F),
        .if_rdata(if_rdata), .if_valid(if_valid), .stall_F(stall_F), .dm_req(dm_req),
        .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_rdata(dm_rdata),
        .dm_valid(dm_valid), .stall_MEM(stall_MEM), .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .mem_ack(mem_ack), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [W-1:0] hash(input logic [W-1:0] a);
        return (a * 32'h9E3779B1) ^ 32'h00500093;
    endfunction

    function automatic logic [W-1:0] ref_rd(input logic [W-1:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : hash(a);
    endfunction

    function automatic logic [W-1:0] mem_rd(input logic [W-1:0] a);
        return dmem.exists(a) ? dmem[a] : hash(a);
    endfunction

    // memory device: random latency, occasional hang, stray acks while idle
    initial begin
        int n = 0, d = 0;
        bit exp_to = 0;
        forever begin
            @(negedge clk);
            mem_ack = 0;
            if (!rst) begin
                n = 0;
                exp_to = 0;
                continue;
            end
            chk("timeout_err", 32'(timeout_err), 32'(exp_to));
            if (exp_to) chk("mem_req_after_timeout", 32'(mem_req), 0);
            exp_to = 0;
            if (mem_req) begin
                if (n == 0)
                    d = mute ? -1 : (!no_to && $urandom % 8 == 0) ? -1 :
                        ($urandom % 6 == 0) ? TO - 1 : int'($urandom_range(0, 3));
                if (n == d) begin
                    mem_ack = 1;
                    mem_rdata = mem_rd(mem_addr);
                    if (mem_we) dmem[mem_addr] = mem_wdata;
                    n = 0;
                end else if (n == TO - 1) begin
                    exp_to = 1;
                    n = 0;
                end else n++;
            end else if (!mute && $urandom % 8 == 0) begin
                mem_ack = 1;
                mem_rdata = $urandom;
            end
        end
    end

    // monitor: pops expected responses on valid, otherwise rdata must hold
    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                if (if_valid) begin
                    if (if_q.size() == 0) chk("if_valid_unexpected", 32'(if_valid), 0);
                    else begin
                        if_last = if_q.pop_front();
                        chk("if_rdata", if_rdata, if_last);
                        if (chk_starve) chk("starve_data_grants", 32'(dm_since_if), 32'(SL));
                    end
                    dm_since_if = 0;
                end else chk("if_rdata_hold", if_rdata, if_last);
                if (dm_valid) begin
                    dm_since_if++;
                    if (dm_q.size() == 0) chk("dm_valid_unexpected", 32'(dm_valid), 0);
                    else begin
                        dm_last = dm_q.pop_front();
                        chk("dm_rdata", dm_rdata, dm_last);
                    end
                end else chk("dm_rdata_hold", dm_rdata, dm_last);
            end
        end
    end

    task automatic dm_ops(input int n, input bit loads_only, input int max_gap);
        for (int i = 0; i < n; i++) begin
            int t = 0, gap;
            dm_req   = 1;
            dm_we    = loads_only ? 1'b0 : ($urandom % 3 == 0);
            dm_addr  = 32'h2000 + 4 * $urandom_range(0, 15);
            dm_wdata = $urandom;
            if (dm_we) begin
                ref_mem[dm_addr] = dm_wdata;
                dm_q.push_back(dm_last_model);
            end else begin
                dm_last_model = ref_rd(dm_addr);
                dm_q.push_back(dm_last_model);
            end
            forever begin
                @(negedge clk);
                chk("stall_MEM", 32'(stall_MEM), 32'(!dm_valid));
                if (dm_valid) break;
                if (++t > 400) begin
                    chk("dm_wait_bound", 32'(dm_valid), 1);
                    break;
                end
            end
            gap = $urandom_range(0, max_gap);
            if (gap > 0) begin
                dm_req = 0;
                repeat (gap) @(negedge clk);
            end
        end
        dm_req = 0;
    endtask

    task automatic if_ops(input int n, input bit allow_flush, input int max_gap);
        for (int i = 0; i < n; i++) begin
            int t = 0, gap, k;
            bit fl;
            if_req  = 1;
            if_addr = 4 * $urandom_range(0, 1023);
            if_q.push_back(hash(if_addr));
            fl = allow_flush && ($urandom % 4 == 0);
            k  = $urandom_range(0, 12);
            forever begin
                @(negedge clk);
                chk("stall_F", 32'(stall_F), 32'(!if_valid));
                if (if_valid) break;
                if (fl && t == k) begin
                    void'(if_q.pop_back());
                    flush_F = 1;
                    if_req  = 0;
                    @(negedge clk);
                    flush_F = 0;
                    break;
                end
                if (++t > 600) begin
                    chk("if_wait_bound", 32'(if_valid), 1);
                    break;
                end
            end
            gap = $urandom_range(0, max_gap);
            if (gap > 0) begin
                if_req = 0;
                repeat (gap) @(negedge clk);
            end
        end
        if_req = 0;
    endtask

    initial begin
        #1000000;
        $display("FAIL global_time_limit reached at %0t", $time);
        $fatal(1, "simulation time limit");
    end

    initial begin
        int t;
        repeat (2) @(negedge clk);
        chk("rst_mem_req", 32'(mem_req), 0);
        chk("rst_if_valid", 32'(if_valid), 0);
        chk("rst_dm_valid", 32'(dm_valid), 0);
        chk("rst_timeout_err", 32'(timeout_err), 0);
        chk("rst_if_rdata", if_rdata, 0);
        chk("rst_dm_rdata", dm_rdata, 0);
        #2 rst = 1;

        @(negedge clk);
        chk_starve = 1;
        no_to = 1;
        fork
            dm_ops(6, 1, 0);
            if_ops(1, 0, 0);
        join
        chk_starve = 0;
        no_to = 0;

        @(negedge clk);
        fork
            dm_ops(150, 0, 3);
            if_ops(150, 1, 3);
        join
        repeat (3) @(negedge clk);
        chk("if_queue_drained", if_q.size(), 0);
        chk("dm_queue_drained", dm_q.size(), 0);

        mute = 1;
        dm_req = 1;
        dm_we = 0;
        dm_addr = 32'h2000;
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (!mem_req && t < 20);
        chk("mem_req_before_reset", 32'(mem_req), 1);
        #2 rst = 0;
        #1;
        chk("async_rst_mem_req", 32'(mem_req), 0);
        chk("async_rst_dm_valid", 32'(dm_valid), 0);
        chk("async_rst_dm_rdata", dm_rdata, 0);
        chk("async_rst_if_rdata", if_rdata, 0);
        dm_req = 0;
        if_q.delete();
        dm_q.delete();
        if_last = 0;
        dm_last = 0;
        @(negedge clk);
        #2 rst = 1;
        mute = 0;
        repeat (6) begin
            @(negedge clk);
            chk("post_reset_mem_req", 32'(mem_req), 0);
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
